// File: rtl/ca_pkg.sv
// Shared definitions for the cellular-automaton scanline engine: defaults,
// state encoding, LFSR constants and the Wolfram rule lookup.
package ca_pkg;

    localparam int CA_WIDTH_DEF  = 640;
    localparam int CA_HEIGHT_DEF = 480;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        DRAW       = 1'b1
    } ca_state_e;

    function automatic logic rule_lookup(
        input logic [7:0] rule,
        input logic       l,
        input logic       c,
        input logic       r
    );
        return rule[{l, c, r}];
    endfunction

endpackage

// File: rtl/ca_lfsr16.sv
// 16-bit free-running Fibonacci LFSR supplying random seed bits; advances
// every clock and exposes its low bit.
module ca_lfsr16
    import ca_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    output logic bit_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/ca_row_engine.sv
// Elementary cellular automaton pixel source: one generation per scanline,
// registered RGB one clock after the coordinate. Define CA_WRAP_EN for a
// toroidal row boundary; otherwise neighbours beyond the row read as 0.
module ca_row_engine
    import ca_pkg::*;
#(
    parameter int          WIDTH     = CA_WIDTH_DEF,
    parameter int          HEIGHT    = CA_HEIGHT_DEF,
    parameter logic [29:0] ALIVE_RGB = {10'h3FF, 10'h3FF, 10'h3FF},
    parameter logic [29:0] DEAD_RGB  = 30'h0
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [9:0] iCoord_X,
    input  logic [9:0] iCoord_Y,
    input  logic [7:0] iRule,
    input  logic       iSeed_Mode,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic       oFrame_Start
);

`ifdef CA_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    localparam logic [9:0] X_LIM  = 10'(WIDTH);
    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] Y_LIM  = 10'(HEIGHT);
    localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);

    ca_state_e        state_q, state_d;
    logic [9:0]       prev_y_q;
    logic             line_started_q, line_started_d;
    logic             line_full_q, line_full_d;
    logic [WIDTH-1:0] cur_row_q, cur_row_d;
    logic [WIDTH-1:0] next_row_q, next_row_d;
    logic [7:0]       rule_q, rule_d;
    logic [29:0]      rgb_q, rgb_d;
    logic             frame_start_q;

    logic             line_change;
    logic             pix_valid;
    logic             commit;
    logic             swap;
    logic             seed_fill;
    logic             lfsr_bit;
    logic             pix_alive;
    logic             started_base;
    logic [WIDTH+1:0] row_pad;
    logic [WIDTH-1:0] pix_sel;
    logic [WIDTH-1:0] cell_next;

    ca_lfsr16 u_lfsr (
        .clk_i (iCLK),
        .rst_i (iRST),
        .bit_o (lfsr_bit)
    );

    assign line_change = (iCoord_Y != prev_y_q);
    assign pix_valid   = (iCoord_X < X_LIM) && (iCoord_Y < Y_LIM);

    // A seed only becomes generation 0 if the line before Y=0 was seen
    // complete; once drawing, line HEIGHT-1 always re-seeds so commit freely.
    assign commit = line_change && (iCoord_Y == 10'd0)
                    && ((state_q == DRAW) || line_full_q);
    assign swap   = line_change && (state_q == DRAW)
                    && (iCoord_Y != 10'd0) && (iCoord_Y < Y_LIM);

    always_comb begin
        state_d = state_q;
        if (commit) begin
            state_d = DRAW;
        end
    end

    always_comb begin
        cur_row_d = cur_row_q;
        rule_d    = rule_q;
        if (commit || swap) begin
            cur_row_d = next_row_q;
        end
        if (commit) begin
            rule_d = iRule;
        end
    end

    // Pixel logic sees the post-swap row so the first pixel of a line is right.
    assign row_pad   = {(WRAP_EN & cur_row_d[0]), cur_row_d, (WRAP_EN & cur_row_d[WIDTH-1])};
    assign seed_fill = (state_d == WAIT_FRAME) || (iCoord_Y == Y_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            localparam logic CENTRE = (gi == WIDTH / 2);
            logic seed_bit;

            assign pix_sel[gi]    = pix_valid && (iCoord_X == 10'(gi));
            assign cell_next[gi]  = rule_lookup(rule_d, row_pad[gi], row_pad[gi+1], row_pad[gi+2]);
            assign seed_bit       = iSeed_Mode ? lfsr_bit : CENTRE;
            assign next_row_d[gi] = !pix_sel[gi] ? next_row_q[gi]
                                  : (seed_fill ? seed_bit : cell_next[gi]);
        end
    endgenerate

    assign pix_alive = |(pix_sel & cur_row_d);

    always_comb begin
        rgb_d = DEAD_RGB;
        if ((state_d == DRAW) && pix_alive) begin
            rgb_d = ALIVE_RGB;
        end
    end

    // line_full only counts lines observed from X=0, so a reset mid-line
    // cannot promote a partially filled seed.
    always_comb begin
        started_base   = line_change ? 1'b0 : line_started_q;
        line_started_d = started_base | (pix_valid && (iCoord_X == 10'd0));
        line_full_d    = (line_change ? 1'b0 : line_full_q)
                         | (pix_valid && (iCoord_X == X_LAST) && started_base);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            prev_y_q       <= 10'h3FF;
            line_started_q <= 1'b0;
            line_full_q    <= 1'b0;
            cur_row_q      <= '0;
            next_row_q     <= '0;
            rule_q         <= 8'd0;
            rgb_q          <= 30'h0;
            frame_start_q  <= 1'b0;
        end else begin
            prev_y_q       <= iCoord_Y;
            line_started_q <= line_started_d;
            line_full_q    <= line_full_d;
            cur_row_q      <= cur_row_d;
            next_row_q     <= next_row_d;
            rule_q         <= rule_d;
            rgb_q          <= rgb_d;
            frame_start_q  <= commit;
        end
    end

    assign oRed         = rgb_q[29:20];
    assign oGreen       = rgb_q[19:10];
    assign oBlue        = rgb_q[9:0];
    assign oFrame_Start = frame_start_q;

endmodule

// File: tb/tb_ca_row_engine.sv
// Scoreboard bench for ca_row_engine on a reduced 32x40 raster: a generation
// level model predicts every pixel and frame pulse; a monitor checks them.
module tb_ca_row_engine;

    localparam int W = 32;
    localparam int H = 40;
    localparam logic [29:0] ALIVE = {10'h3FF, 10'h3FF, 10'h3FF};

`ifdef CA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] cx = 10'd0;
    logic [9:0] cy = 10'd0;
    logic [7:0] rule = 8'd90;
    logic       mode = 1'b0;
    logic [9:0] red, green, blue;
    logic       fs;

    always #5 clk = ~clk;

    ca_row_engine #(.WIDTH(W), .HEIGHT(H)) dut (
        .iCLK         (clk),
        .iRST         (rst),
        .iCoord_X     (cx),
        .iCoord_Y     (cy),
        .iRule        (rule),
        .iSeed_Mode   (mode),
        .oRed         (red),
        .oGreen       (green),
        .oBlue        (blue),
        .oFrame_Start (fs)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [29:0] rgb;
        logic        fs;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    int frame_no = 0;
    logic [W-1:0] cap [H];

    // Reference model: the displayed row is a generation index, not a buffer.
    logic [9:0]   m_prev_y;
    bit           m_started, m_full, m_draw;
    logic [7:0]   m_rule;
    logic [W-1:0] m_row, m_seed;
    logic [15:0]  m_lfsr;

    function automatic logic [W-1:0] ca_step(input logic [W-1:0] row, input logic [7:0] rl);
        logic [W-1:0] nxt;
        int l, c, r;
        for (int i = 0; i < W; i++) begin
            if (i > 0) l = int'(row[i-1]);
            else       l = WRAP ? int'(row[W-1]) : 0;
            if (i < W - 1) r = int'(row[i+1]);
            else           r = WRAP ? int'(row[0]) : 0;
            c = int'(row[i]);
            nxt[i] = rl[l * 4 + c * 2 + r];
        end
        return nxt;
    endfunction

    function automatic logic [W-1:0] mk(input int p0, input int p1 = -1,
                                        input int p2 = -1, input int p3 = -1);
        logic [W-1:0] v;
        v = '0;
        if (p0 >= 0) v[p0] = 1'b1;
        if (p1 >= 0) v[p1] = 1'b1;
        if (p2 >= 0) v[p2] = 1'b1;
        if (p3 >= 0) v[p3] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_prev_y  = 10'h3FF;
        m_started = 0;
        m_full    = 0;
        m_draw    = 0;
        m_rule    = 8'd0;
        m_row     = '0;
        m_seed    = '0;
        m_lfsr    = 16'hACE1;
    endtask

    // Called at a falling edge; presents one coordinate, returns at the next falling edge.
    task automatic drive(input logic [9:0] x, input logic [9:0] y);
        bit lc, commit, valid, full_old, sb;
        logic [W-1:0] tmp, one;
        exp_t e;
        cx = x;
        cy = y;
        one = 1;
        lc = (y != m_prev_y);
        commit = 0;
        if (lc) begin
            full_old  = m_full;
            m_started = 0;
            m_full    = 0;
            if (y == 10'd0 && (m_draw || full_old)) begin
                commit = 1;
                m_draw = 1;
                m_rule = rule;
                m_row  = m_seed;
            end else if (m_draw && int'(y) < H) begin
                m_row = ca_step(m_row, m_rule);
            end
        end
        valid = (int'(x) < W) && (int'(y) < H);
        if (valid) begin
            if (int'(x) == W - 1 && m_started) m_full = 1;
            if (x == 10'd0) m_started = 1;
            if (!m_draw || int'(y) == H - 1) begin
                sb = mode ? m_lfsr[0] : (int'(x) == W / 2);
                m_seed = (m_seed & ~(one << x)) | ((sb ? one : '0) << x);
            end
        end
        tmp = m_row >> x;
        e.x   = x;
        e.y   = y;
        e.rgb = (valid && m_draw && tmp[0]) ? ALIVE : 30'h0;
        e.fs  = commit;
        sb_q.push_back(e);
        m_prev_y = y;
        @(posedge clk);
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({red, green, blue} != 30'h0) begin
            failures++;
            $display("FAIL reset_rgb got=%h expected=0", {red, green, blue});
        end
        checks++;
        if (fs !== 1'b0) begin
            failures++;
            $display("FAIL reset_frame_start got=%b expected=0", fs);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input int rule_y, input logic [7:0] new_rule,
                             input bit blank, input int rst_y);
        for (int y = 0; y < H; y++) begin
            if (y == rule_y) rule = new_rule;
            for (int x = 0; x < W; x++) begin
                drive(10'(x), 10'(y));
                if (y == rst_y && x == W / 2 - 1) do_reset();
            end
            drive(10'd700, 10'(y));
        end
        if (blank) begin
            for (int x = 0; x < W; x++) drive(10'(x), 10'd500);
        end
        $display("frame %0d done: drawing=%0d rule=%0d checks=%0d failures=%0d",
                 frame_no, m_draw, m_rule, checks, failures);
        frame_no++;
    endtask

    task automatic check_line(input string name, input int y, input logic [W-1:0] expv);
        checks++;
        if (cap[y] !== expv) begin
            failures++;
            $display("FAIL %s line %0d got=%h expected=%h", name, y, cap[y], expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({red, green, blue} != e.rgb || fs !== e.fs) begin
                    failures++;
                    $display("FAIL pixel x=%0d y=%0d got rgb=%h fs=%b expected rgb=%h fs=%b",
                             e.x, e.y, {red, green, blue}, fs, e.rgb, e.fs);
                end
                if (int'(e.y) < H && int'(e.x) < W)
                    cap[int'(e.y)][int'(e.x)] = ({red, green, blue} == ALIVE);
            end
        end
    end

    initial begin : stimulus
        @(negedge clk);
        do_reset();
        run_frame(-1, 8'd0, 1'b0, -1);             // seed only, nothing shown
        run_frame(-1, 8'd0, 1'b0, -1);             // rule 90 from single cell
        check_line("r90", 0, mk(W / 2));
        check_line("r90", 1, mk(W / 2 - 1, W / 2 + 1));
        check_line("r90", 2, mk(W / 2 - 2, W / 2 + 2));
        check_line("r90", 3, mk(W / 2 - 3, W / 2 - 1, W / 2 + 1, W / 2 + 3));
        run_frame(H / 2, 8'd150, 1'b1, -1);        // rule change mid-frame, then a blank line
        check_line("r90_held", 1, mk(W / 2 - 1, W / 2 + 1));
        run_frame(5, 8'd30, 1'b0, -1);             // rule 150 after commit
        check_line("r150", 1, mk(W / 2 - 1, W / 2, W / 2 + 1));
        mode = 1'b1;
        run_frame(5, 8'($urandom_range(0, 255)), 1'b0, -1);   // rule 30, random seed queued
        check_line("r30", 1, mk(W / 2 - 1, W / 2, W / 2 + 1));
        check_line("r30", 2, mk(W / 2 - 2, W / 2 - 1, W / 2 + 2));
        run_frame(5, 8'($urandom_range(0, 255)), 1'b0, -1);   // random rule, random seed
        mode = 1'b0;
        run_frame(5, 8'd90, 1'b0, H - 1);          // reset on last line mid-way
        run_frame(-1, 8'd0, 1'b0, -1);             // waiting frame, no pulse
        run_frame(-1, 8'd0, 1'b0, -1);             // rule 90 reaching the row edges
        check_line("r90_after_reset", 0, mk(W / 2));
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
